// File: rtl/paddle_quad_encoder_pkg.sv
// Shared types for the paddle-to-quadrature encoder: FSM states, phase codes and
// small arithmetic helpers.
package paddle_quad_encoder_pkg;

    typedef enum logic [1:0] {
        StSync,
        StIdle,
        StMove
    } enc_state_e;

    // {A,B} codes in step-up order
    localparam logic [1:0] PhaseS0 = 2'b00;
    localparam logic [1:0] PhaseS1 = 2'b10;
    localparam logic [1:0] PhaseS2 = 2'b11;
    localparam logic [1:0] PhaseS3 = 2'b01;

    function automatic logic [1:0] phase_next(input logic [1:0] phase, input logic up);
        logic [1:0] nxt;
        nxt = phase;
        case (phase)
            PhaseS0: nxt = up ? PhaseS1 : PhaseS3;
            PhaseS1: nxt = up ? PhaseS2 : PhaseS0;
            PhaseS2: nxt = up ? PhaseS3 : PhaseS1;
            default: nxt = up ? PhaseS0 : PhaseS2;
        endcase
        return nxt;
    endfunction

    // Magnitude of the 9-bit signed difference a - b.
    function automatic logic [8:0] pos_dist(input logic [7:0] a, input logic [7:0] b);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        mag  = diff[8] ? 9'(-diff) : 9'(diff);
        return mag;
    endfunction

endpackage

// File: rtl/paddle_quad_encoder_if.sv
// Sample input and quadrature output bundle of the paddle encoder; the source
// drives the master side, the encoder sits on the slave side.
interface paddle_quad_encoder_if;
    logic       enable;
    logic [7:0] pos_in;
    logic       pos_valid;
    logic       quad_a;
    logic       quad_b;
    logic [7:0] cur_pos;
    logic       busy;

    modport master (
        output enable, pos_in, pos_valid,
        input  quad_a, quad_b, cur_pos, busy
    );

    modport slave (
        input  enable, pos_in, pos_valid,
        output quad_a, quad_b, cur_pos, busy
    );
endinterface

// File: rtl/paddle_quad_encoder_quad_phase_gen.sv
// Two-bit Gray-coded phase register; each step pulse advances one position in
// the chosen direction, so only one of A/B ever toggles per step.
module paddle_quad_encoder_quad_phase_gen
    import paddle_quad_encoder_pkg::*;
(
    input  logic clk_sys,
    input  logic reset,
    input  logic step,
    input  logic up,
    output logic quad_a,
    output logic quad_b
);

    logic [1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        if (step) begin
            phase_d = phase_next(phase_q, up);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            phase_q <= PhaseS0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign quad_a = phase_q[1];
    assign quad_b = phase_q[0];

endmodule

// File: rtl/paddle_quad_encoder.sv
// Converts absolute paddle samples into a rate-limited quadrature stream that
// walks an internal position toward the latest target.
module paddle_quad_encoder
    import paddle_quad_encoder_pkg::*;
#(
    parameter int unsigned CLKDIV   = 5500,
    parameter int unsigned DEADBAND = 1,
    parameter int unsigned INVERT   = 0
) (
    input logic                  clk_sys,
    input logic                  reset,
    paddle_quad_encoder_if.slave bus
);

    localparam logic [15:0] TickLast  = 16'(CLKDIV - 1);
    localparam logic [8:0]  DbLim     = 9'(DEADBAND);
    localparam logic        InvertBit = (INVERT != 0);

    enc_state_e  state_q, state_d;
    logic [7:0]  cur_q, cur_d;
    logic [7:0]  target_q, target_d;
    logic [15:0] tick_q, tick_d;
    logic        step;
    logic        step_up;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        tick_d   = tick_q;
        step     = 1'b0;
        step_up  = (target_q > cur_q);

        if (!bus.enable) begin
            state_d = StSync;
            tick_d  = '0;
        end else begin
            case (state_q)
                StSync: begin
                    if (bus.pos_valid) begin
                        target_d = bus.pos_in;
                        cur_d    = bus.pos_in;
                        state_d  = StIdle;
                    end
                end
                StIdle: begin
                    if (bus.pos_valid) begin
                        target_d = bus.pos_in;
                        if (pos_dist(bus.pos_in, cur_q) > DbLim) begin
                            state_d = StMove;
                            tick_d  = '0;
                        end
                    end
                end
                StMove: begin
                    if (bus.pos_valid) begin
                        target_d = bus.pos_in;
                    end
                    if (tick_q == TickLast) begin
                        tick_d = '0;
                        // The step follows the registered target; stepping toward it
                        // can never leave 0..255, which gives the saturation.
                        if (target_q != cur_q) begin
                            step  = 1'b1;
                            cur_d = step_up ? cur_q + 8'd1 : cur_q - 8'd1;
                        end
                        if (pos_dist(target_d, cur_d) <= DbLim) begin
                            state_d = StIdle;
                        end
                    end else begin
                        tick_d = tick_q + 16'd1;
                    end
                end
                default: state_d = StSync;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= StSync;
            cur_q    <= '0;
            target_q <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            tick_q   <= tick_d;
        end
    end

    paddle_quad_encoder_quad_phase_gen u_quad_phase_gen (
        .clk_sys (clk_sys),
        .reset   (reset),
        .step    (step),
        .up      (step_up ^ InvertBit),
        .quad_a  (bus.quad_a),
        .quad_b  (bus.quad_b)
    );

    assign bus.cur_pos = cur_q;
    assign bus.busy    = (state_q == StMove);

endmodule

// File: tb/tb_paddle_quad_encoder.sv
// Bench for paddle_quad_encoder: two parameterisations share one stimulus stream
// and are checked every cycle against a cycle-level integer model.
module tb_paddle_quad_encoder;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] pos_in;
    logic       pos_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    paddle_quad_encoder_if bus0 ();
    paddle_quad_encoder_if bus1 ();

    assign bus0.enable    = enable;
    assign bus0.pos_in    = pos_in;
    assign bus0.pos_valid = pos_valid;
    assign bus1.enable    = enable;
    assign bus1.pos_in    = pos_in;
    assign bus1.pos_valid = pos_valid;

    paddle_quad_encoder #(.CLKDIV(4), .DEADBAND(1), .INVERT(0)) u_dut0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus0)
    );

    paddle_quad_encoder #(.CLKDIV(3), .DEADBAND(0), .INVERT(1)) u_dut1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus1)
    );

    // Model: 0 = sync, 1 = idle, 2 = move; ph counts net up-steps modulo 4.
    int cd [2] = '{4, 3};
    int db [2] = '{1, 0};
    int inv[2] = '{0, 1};
    int m_st[2], m_cur[2], m_tgt[2], m_tick[2], m_ph[2];

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // {A,B} as an int: up-order 00, 10, 11, 01; inverted units walk it backwards.
    function automatic int quad_of(input int ph, input int iv);
        int seq[4] = '{0, 2, 3, 1};
        int idx;
        idx = iv != 0 ? (4 - ph) % 4 : ph;
        return seq[idx];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int ntgt;
        if (reset) begin
            m_st[k] = 0; m_cur[k] = 0; m_tgt[k] = 0; m_tick[k] = 0; m_ph[k] = 0;
        end else if (!enable) begin
            m_st[k]   = 0;
            m_tick[k] = 0;
        end else if (m_st[k] == 0) begin
            if (pos_valid) begin
                m_tgt[k] = int'(pos_in);
                m_cur[k] = int'(pos_in);
                m_st[k]  = 1;
            end
        end else if (m_st[k] == 1) begin
            if (pos_valid) begin
                m_tgt[k] = int'(pos_in);
                if (absd(m_tgt[k], m_cur[k]) > db[k]) begin
                    m_st[k]   = 2;
                    m_tick[k] = 0;
                end
            end
        end else begin
            ntgt = pos_valid ? int'(pos_in) : m_tgt[k];
            if (m_tick[k] == cd[k] - 1) begin
                m_tick[k] = 0;
                if (m_tgt[k] > m_cur[k]) begin
                    m_cur[k]++;
                    m_ph[k] = (m_ph[k] + 1) % 4;
                end else if (m_tgt[k] < m_cur[k]) begin
                    m_cur[k]--;
                    m_ph[k] = (m_ph[k] + 3) % 4;
                end
                if (absd(ntgt, m_cur[k]) <= db[k]) m_st[k] = 1;
            end else begin
                m_tick[k]++;
            end
            m_tgt[k] = ntgt;
        end
    endtask

    // Cycle-by-cycle scoreboard.
    always begin
        @(posedge clk_sys);
        model_step(0);
        model_step(1);
        #1;
        check("dut0_cur_pos", int'(bus0.cur_pos), m_cur[0]);
        check("dut0_busy", int'(bus0.busy), int'(m_st[0] == 2));
        check("dut0_quad", int'({bus0.quad_a, bus0.quad_b}), quad_of(m_ph[0], inv[0]));
        check("dut1_cur_pos", int'(bus1.cur_pos), m_cur[1]);
        check("dut1_busy", int'(bus1.busy), int'(m_st[1] == 2));
        check("dut1_quad", int'({bus1.quad_a, bus1.quad_b}), quad_of(m_ph[1], inv[1]));
    end

    task automatic pulse(input int v);
        @(negedge clk_sys);
        pos_in    = 8'(v);
        pos_valid = 1'b1;
        @(negedge clk_sys);
        pos_valid = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        pos_in    = 8'd0;
        pos_valid = 1'b0;
        wait_edges(3);
        check("reset_cur_pos", int'(bus0.cur_pos), 0);
        check("reset_quad", int'({bus0.quad_a, bus0.quad_b}), 0);
        @(negedge clk_sys);
        reset  = 1'b0;
        enable = 1'b1;

        // Sync from 128: no step.
        pulse(128);
        wait_edges(1);
        check("sync_cur_pos", int'(bus0.cur_pos), 128);
        check("sync_busy", int'(bus0.busy), 0);
        check("sync_quad", int'({bus0.quad_a, bus0.quad_b}), 0);

        // 128 -> 132 with deadband 1: three up-steps, first after 4 cycles.
        pulse(132);
        wait_edges(3);
        check("up_before_first", int'(bus0.cur_pos), 128);
        check("up_busy", int'(bus0.busy), 1);
        wait_edges(1);
        check("up_first_step", int'(bus0.cur_pos), 129);
        check("up_first_quad", int'({bus0.quad_a, bus0.quad_b}), 2);
        wait_edges(8);
        check("up_final_pos", int'(bus0.cur_pos), 131);
        check("up_final_quad", int'({bus0.quad_a, bus0.quad_b}), 1);
        check("up_busy_fall", int'(bus0.busy), 0);

        // 131 -> 120: ten down-steps.
        pulse(120);
        wait_edges(40);
        check("down_final_pos", int'(bus0.cur_pos), 121);
        check("down_final_quad", int'({bus0.quad_a, bus0.quad_b}), 2);
        check("down_busy_fall", int'(bus0.busy), 0);

        // Reverse mid-move: tick phase kept, next step goes down.
        pulse(200);
        wait_edges(10);
        check("rev_pre_pos", int'(bus0.cur_pos), 123);
        pulse(100);
        wait_edges(1);
        check("rev_first_down", int'(bus0.cur_pos), 122);
        wait_edges(4);
        check("rev_spacing", int'(bus0.cur_pos), 121);

        // Saturation at 0.
        pulse(1);
        wait_edges(1100);
        check("sat_dut0_park", int'(bus0.cur_pos), 2);
        check("sat_dut1_park", int'(bus1.cur_pos), 1);
        pulse(0);
        wait_edges(10);
        check("sat_dut0_pos", int'(bus0.cur_pos), 1);
        check("sat_dut1_pos", int'(bus1.cur_pos), 0);
        pulse(0);
        wait_edges(1);
        check("sat_dut1_hold", int'(bus1.cur_pos), 0);
        check("sat_dut1_busy", int'(bus1.busy), 0);

        // Enable drop mid-move freezes outputs.
        pulse(60);
        wait_edges(6);
        check("en_move_pos", int'(bus0.cur_pos), 2);
        @(negedge clk_sys);
        enable = 1'b0;
        wait_edges(9);
        check("en_off_pos", int'(bus0.cur_pos), 2);
        check("en_off_busy", int'(bus0.busy), 0);
        @(negedge clk_sys);
        enable = 1'b1;
        pulse(60);
        wait_edges(2);
        check("en_resync_pos", int'(bus0.cur_pos), 60);
        check("en_resync_busy", int'(bus0.busy), 0);

        // Asynchronous reset mid-move.
        pulse(10);
        wait_edges(5);
        check("rst_move_pos", int'(bus0.cur_pos), 59);
        @(negedge clk_sys);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pos0", int'(bus0.cur_pos), 0);
        check("async_rst_busy0", int'(bus0.busy), 0);
        check("async_rst_quad0", int'({bus0.quad_a, bus0.quad_b}), 0);
        check("async_rst_pos1", int'(bus1.cur_pos), 0);
        check("async_rst_quad1", int'({bus1.quad_a, bus1.quad_b}), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        pulse(50);
        wait_edges(1);
        check("rst_resync_pos", int'(bus0.cur_pos), 50);
        check("rst_resync_quad", int'({bus0.quad_a, bus0.quad_b}), 0);
        check("rst_resync_busy", int'(bus0.busy), 0);

        // Randomised traffic against the model.
        for (int c = 0; c < 6000; c++) begin
            int v;
            @(negedge clk_sys);
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            pos_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: v = ($urandom_range(0, 1) == 0) ? 0 : 255;
                1: v = m_cur[0] + int'($urandom_range(0, 4)) - 2;
                default: v = int'($urandom_range(0, 255));
            endcase
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            pos_in = 8'(v);
        end
        @(negedge clk_sys);
        reset     = 1'b0;
        pos_valid = 1'b0;
        wait_edges(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/paddle_quad_encoder.md
PADDLE_QUAD_ENCODER -- requirements
Module: paddle_quad_encoder

Interface
REQ-001 Parameter CLKDIV, default 5500: clk_sys cycles per quadrature step; legal range 2..65535.
REQ-002 Parameter DEADBAND, default 1: |target-current| at or below this value produces no steps.
REQ-003 Parameter INVERT, default 0: when 1, swaps step direction (A/B sequence reversed).
REQ-004 clk_sys  in  1  system clock (12 MHz); one clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  1 = paddle/analog source selected; 0 = encoder idle.
REQ-007 pos_in  in  8  absolute unsigned position, 0 = full left, 255 = full right.
REQ-008 pos_valid  in  1  one-cycle strobe marking pos_in as a new sample.
REQ-009 quad_a  out  1  quadrature phase A, feeds game Enc_A.
REQ-010 quad_b  out  1  quadrature phase B, feeds game Enc_B.
REQ-011 cur_pos  out  8  internal tracked position.
REQ-012 busy  out  1  1 while state is MOVE.

Function
REQ-013 FSM states: SYNC, IDLE, MOVE; reset state SYNC.
REQ-014 SYNC: first pos_valid with enable=1 loads target and cur_pos from pos_in; no step emitted; next state IDLE.
REQ-015 IDLE: pos_valid with enable=1 loads target; when |target-cur_pos| > DEADBAND, enter MOVE and clear the tick counter.
REQ-016 MOVE: tick counter counts 0..CLKDIV-1; on terminal count take exactly one step toward target; return to IDLE once |target-cur_pos| <= DEADBAND after a step.
REQ-017 Difference is computed as a 9-bit signed value; cur_pos saturates at 0 and 255; no wrap-around.
REQ-018 Step up: cur_pos+1; phase {A,B} advances 00->10->11->01->00. Step down: cur_pos-1; reverse sequence. INVERT=1 swaps the two sequences and leaves cur_pos arithmetic unchanged.
REQ-019 quad_a/quad_b are registered and change only on the cycle that the step is taken; at most one phase bit changes per step.
REQ-020 Step latency: first step occurs exactly CLKDIV cycles after MOVE entry.
REQ-021 A target update during MOVE takes effect at the next tick; the tick counter is not cleared. If the direction reverses, the next step follows the new direction.
REQ-022 enable falling: within one cycle go to SYNC; quad_a/quad_b hold their last value; tick counter cleared; pos_valid ignored while enable=0.
REQ-023 pos_valid simultaneous with a tick: the step uses the old target; the new target is loaded in the same cycle.
REQ-024 Maximum slew is one count per CLKDIV cycles; excess motion is absorbed by continued MOVE, never dropped.

Reset
REQ-025 Reset asserted: state=SYNC, cur_pos=0, target=0, tick=0, quad_a=0, quad_b=0, busy=0, effective asynchronously.
REQ-026 Reset deassertion mid-MOVE: no residual step; tracking restarts from SYNC behaviour.

Structure
REQ-027 Shared package holds the state enum (SYNC/IDLE/MOVE) and the 2-bit quadrature phase constants.
REQ-028 One sub-module, quad_phase_gen: 2-bit phase register with step/dir inputs, driving quad_a/quad_b.
REQ-029 Top-level instantiates this block alongside the existing joystick-to-quadrature path; a source selector muxes Enc_A/Enc_B.

Verification
REQ-030 Reset release, enable=1, pos_valid with pos_in=128 -> cur_pos=128, zero A/B transitions, state IDLE.
REQ-031 From 128, pos_in=132, CLKDIV=4, DEADBAND=1 -> 3 steps, one every 4 cycles (first 4 cycles after MOVE entry), sequence 00->10->11->01, cur_pos=131, busy falls.
REQ-032 From 131, pos_in=120 -> 10 down-steps with reversed sequence; cur_pos=121; at most one phase bit changes per step.
REQ-033 During MOVE toward 200, pos_in=100 -> direction reverses at the next tick; tick counter not reset; step spacing stays CLKDIV.
REQ-034 cur_pos=1, pos_in=0, DEADBAND=0 -> one step to 0; further pos_in=0 samples produce no steps (saturation).
REQ-035 enable dropped mid-MOVE, then reset pulse mid-MOVE -> outputs frozen, then all outputs 0 asynchronously; re-enable with pos_in=50 resyncs with no step.
